// File: rtl/regfile_sb_pkg.sv
`default_nettype none
// ============================================================================
// regfile_sb_pkg : shared sizes and types for the register file / scoreboard
// Revision 1.0
// ============================================================================
package regfile_sb_pkg;
   localparam int XLEN  = 64;
   localparam int NREG  = 32;
   localparam int CNTW  = 2;
   localparam int IDX_W = 5;

   typedef logic [IDX_W-1:0] reg_idx_t;

   localparam reg_idx_t X0 = '0;
endpackage
`default_nettype wire

// File: rtl/regfile_sb_if.sv
`default_nettype none
// ============================================================================
// regfile_sb_if : writeback, cancel, read and issue signals of regfile_sb
// Revision 1.0
// ============================================================================
interface regfile_sb_if #(
   parameter int XLEN = regfile_sb_pkg::XLEN
);
   import regfile_sb_pkg::*;

   logic [XLEN-1:0] wb_data;
   reg_idx_t        wb_addr;
   logic            wb_is_write_rf;
   logic            cancel_valid;
   reg_idx_t        cancel_addr;
   reg_idx_t        rs1_addr;
   reg_idx_t        rs2_addr;
   logic            rs1_used;
   logic            rs2_used;
   logic [XLEN-1:0] rs1_data;
   logic [XLEN-1:0] rs2_data;
   logic            issue_valid;
   logic            issue_wen;
   reg_idx_t        issue_rd;
   logic            issue_stall;

   modport master (
      output wb_data, wb_addr, wb_is_write_rf, cancel_valid, cancel_addr,
             rs1_addr, rs2_addr, rs1_used, rs2_used,
             issue_valid, issue_wen, issue_rd,
      input  rs1_data, rs2_data, issue_stall
   );

   modport slave (
      input  wb_data, wb_addr, wb_is_write_rf, cancel_valid, cancel_addr,
             rs1_addr, rs2_addr, rs1_used, rs2_used,
             issue_valid, issue_wen, issue_rd,
      output rs1_data, rs2_data, issue_stall
   );
endinterface
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// regfile_scoreboard : per-register pending-write counters and issue stall
// Revision 1.0
// ============================================================================
module regfile_scoreboard
   import regfile_sb_pkg::*;
#(
   parameter int NREG = regfile_sb_pkg::NREG,
   parameter int CNTW = regfile_sb_pkg::CNTW
) (
   input  wire logic     clk,
   input  wire logic     rst,
   input  wire logic     wb_valid,
   input  wire reg_idx_t wb_addr,
   input  wire logic     cancel_valid,
   input  wire reg_idx_t cancel_addr,
   input  wire reg_idx_t rs1_addr,
   input  wire reg_idx_t rs2_addr,
   input  wire logic     rs1_used,
   input  wire logic     rs2_used,
   input  wire logic     issue_valid,
   input  wire logic     issue_wen,
   input  wire reg_idx_t issue_rd,
   output logic          issue_stall
);
   localparam int             UPW      = CNTW + 1;
   localparam logic [CNTW-1:0] PEND_MAX = '1;
   localparam logic [CNTW-1:0] PEND_ONE = CNTW'(1);

   logic [CNTW-1:0] pend     [NREG];
   logic [CNTW-1:0] pend_nxt [NREG];

   logic            wb_dec;
   logic            cancel_dec;
   logic            busy1;
   logic            busy2;
   logic            hazard1;
   logic            hazard2;
   logic            full;
   logic            inc;
   logic [UPW-1:0]  up;
   logic [UPW-1:0]  dn;

   assign wb_dec     = wb_valid && (wb_addr != X0);
   assign cancel_dec = cancel_valid && (cancel_addr != X0);

   // A count of one whose write lands this cycle is covered by the bypass.
   always_comb begin
      busy1 = (pend[rs1_addr] > PEND_ONE) ||
              ((pend[rs1_addr] == PEND_ONE) && !(wb_dec && (wb_addr == rs1_addr)));
      busy2 = (pend[rs2_addr] > PEND_ONE) ||
              ((pend[rs2_addr] == PEND_ONE) && !(wb_dec && (wb_addr == rs2_addr)));
      hazard1     = rs1_used && (rs1_addr != X0) && busy1;
      hazard2     = rs2_used && (rs2_addr != X0) && busy2;
      full        = issue_wen && (issue_rd != X0) && (pend[issue_rd] == PEND_MAX);
      issue_stall = issue_valid && (hazard1 || hazard2 || full);
      inc         = issue_valid && !issue_stall && issue_wen && (issue_rd != X0);
   end

   always_comb begin
      up = '0;
      dn = '0;
      for (int r = 0; r < NREG; r++) begin
         up = {1'b0, pend[r]} + UPW'(inc && (issue_rd == reg_idx_t'(r)));
         dn = UPW'(wb_dec && (wb_addr == reg_idx_t'(r))) +
              UPW'(cancel_dec && (cancel_addr == reg_idx_t'(r)));
         if (r == 0) begin
            pend_nxt[r] = '0;
         end else if (up >= dn) begin
            pend_nxt[r] = CNTW'(up - dn);
         end else begin
            pend_nxt[r] = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < NREG; r++) begin
            pend[r] <= '0;
         end
      end else begin
         pend <= pend_nxt;
      end
   end
endmodule
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// regfile_sb : bypassed two-read register file with write-tracking scoreboard
// Revision 1.0
// ============================================================================
module regfile_sb
   import regfile_sb_pkg::*;
#(
   parameter int XLEN = regfile_sb_pkg::XLEN,
   parameter int NREG = regfile_sb_pkg::NREG,
   parameter int CNTW = regfile_sb_pkg::CNTW
) (
   input  wire logic     clk,
   input  wire logic     rst,
   regfile_sb_if.slave   bus
);
   logic [XLEN-1:0] regs [NREG];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < NREG; r++) begin
            regs[r] <= '0;
         end
      end else if (bus.wb_is_write_rf && (bus.wb_addr != X0)) begin
         regs[bus.wb_addr] <= bus.wb_data;
      end
   end

   always_comb begin
      if (bus.rs1_addr == X0) begin
         bus.rs1_data = '0;
      end else if (bus.wb_is_write_rf && (bus.wb_addr == bus.rs1_addr)) begin
         bus.rs1_data = bus.wb_data;
      end else begin
         bus.rs1_data = regs[bus.rs1_addr];
      end

      if (bus.rs2_addr == X0) begin
         bus.rs2_data = '0;
      end else if (bus.wb_is_write_rf && (bus.wb_addr == bus.rs2_addr)) begin
         bus.rs2_data = bus.wb_data;
      end else begin
         bus.rs2_data = regs[bus.rs2_addr];
      end
   end

   regfile_scoreboard #(
      .NREG (NREG),
      .CNTW (CNTW)
   ) u_scoreboard (
      .clk          (clk),
      .rst          (rst),
      .wb_valid     (bus.wb_is_write_rf),
      .wb_addr      (bus.wb_addr),
      .cancel_valid (bus.cancel_valid),
      .cancel_addr  (bus.cancel_addr),
      .rs1_addr     (bus.rs1_addr),
      .rs2_addr     (bus.rs2_addr),
      .rs1_used     (bus.rs1_used),
      .rs2_used     (bus.rs2_used),
      .issue_valid  (bus.issue_valid),
      .issue_wen    (bus.issue_wen),
      .issue_rd     (bus.issue_rd),
      .issue_stall  (bus.issue_stall)
   );
endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
// tb_regfile_sb : directed and randomized checks of regfile_sb against a model
// Revision 1.0
// ============================================================================
module tb_regfile_sb;
   import regfile_sb_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   regfile_sb_if bus ();

   regfile_sb dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int          checks   = 0;
   int          errors   = 0;
   bit          model_on = 1'b0;
   logic [63:0] mregs [32];
   int          mpend [32];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] m_read(input logic [4:0] a);
      if (a == 0) return 64'd0;
      if (bus.wb_is_write_rf && bus.wb_addr == a) return bus.wb_data;
      return mregs[a];
   endfunction

   function automatic bit m_hazard(input bit used, input logic [4:0] a);
      int e;
      e = mpend[a] - ((bus.wb_is_write_rf && bus.wb_addr == a) ? 1 : 0);
      if (e < 0) e = 0;
      return used && a != 0 && e != 0;
   endfunction

   function automatic bit m_stall();
      bit full;
      full = bus.issue_wen && bus.issue_rd != 0 && mpend[bus.issue_rd] == 3;
      return bus.issue_valid &&
             (m_hazard(bus.rs1_used, bus.rs1_addr) || m_hazard(bus.rs2_used, bus.rs2_addr) || full);
   endfunction

   // Compare against the model, then advance the model to the next edge.
   always @(negedge clk) begin : cmp
      bit s;
      int n;
      if (model_on) begin
         chk("rs1_data", bus.rs1_data, m_read(bus.rs1_addr));
         chk("rs2_data", bus.rs2_data, m_read(bus.rs2_addr));
         chk("issue_stall", 64'(bus.issue_stall), 64'(m_stall()));
      end
      if (rst) begin
         for (int r = 0; r < 32; r++) begin
            mregs[r] = 64'd0;
            mpend[r] = 0;
         end
      end else begin
         s = m_stall();
         for (int r = 1; r < 32; r++) begin
            n = mpend[r];
            if (bus.issue_valid && !s && bus.issue_wen && bus.issue_rd == r) n++;
            if (bus.wb_is_write_rf && bus.wb_addr == r) n--;
            if (bus.cancel_valid && bus.cancel_addr == r) n--;
            mpend[r] = (n < 0) ? 0 : n;
         end
         if (bus.wb_is_write_rf && bus.wb_addr != 0) mregs[bus.wb_addr] = bus.wb_data;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.wb_data        = '0;
      bus.wb_addr        = '0;
      bus.wb_is_write_rf = 1'b0;
      bus.cancel_valid   = 1'b0;
      bus.cancel_addr    = '0;
      bus.rs1_addr       = '0;
      bus.rs2_addr       = '0;
      bus.rs1_used       = 1'b0;
      bus.rs2_used       = 1'b0;
      bus.issue_valid    = 1'b0;
      bus.issue_wen      = 1'b0;
      bus.issue_rd       = '0;
   endtask

   task automatic wb(input logic [4:0] a, input logic [63:0] d);
      bus.wb_is_write_rf = 1'b1;
      bus.wb_addr        = a;
      bus.wb_data        = d;
   endtask

   task automatic issue(input logic [4:0] rd);
      bus.issue_valid = 1'b1;
      bus.issue_wen   = 1'b1;
      bus.issue_rd    = rd;
   endtask

   initial begin
      for (int r = 0; r < 32; r++) begin
         mregs[r] = 64'd0;
         mpend[r] = 0;
      end
      idle();
      rst = 1'b1;
      tick();
      tick();
      model_on = 1'b1;
      rst = 1'b0;

      for (int i = 1; i < 32; i++) begin
         idle(); bus.rs1_addr = 5'(i); #1;
         chk("reset_read", bus.rs1_data, 64'd0);
         tick();
      end

      idle(); wb(5, 64'h1234); tick();
      idle(); bus.rs1_addr = 5; #1;
      chk("write_x5", bus.rs1_data, 64'h1234);
      wb(0, 64'hFFFF); tick();
      idle(); bus.rs2_addr = 0; #1;
      chk("x0_zero", bus.rs2_data, 64'd0);

      wb(7, 64'hABCD); bus.rs1_addr = 7; #1;
      chk("bypass_x7", bus.rs1_data, 64'hABCD);
      tick();

      idle(); issue(3); #1;
      chk("raw_issue", 64'(bus.issue_stall), 64'd0);
      tick();
      idle(); bus.issue_valid = 1'b1; bus.rs2_addr = 3; bus.rs2_used = 1'b1; #1;
      chk("raw_stall", 64'(bus.issue_stall), 64'd1);
      wb(3, 64'h55); #1;
      chk("raw_wb_clear", 64'(bus.issue_stall), 64'd0);
      chk("raw_wb_data", bus.rs2_data, 64'h55);
      tick();

      idle();
      for (int i = 0; i < 3; i++) begin
         issue(9); #1;
         chk("sat_issue", 64'(bus.issue_stall), 64'd0);
         tick();
      end
      issue(9); #1;
      chk("sat_full", 64'(bus.issue_stall), 64'd1);
      tick();
      wb(9, 64'h99); #1;
      chk("sat_full_wb", 64'(bus.issue_stall), 64'd1);
      tick();
      idle(); issue(9); #1;
      chk("sat_reissue", 64'(bus.issue_stall), 64'd0);
      tick();
      #1;
      chk("sat_stays3", 64'(bus.issue_stall), 64'd1);
      idle();
      for (int i = 0; i < 3; i++) begin
         wb(9, 64'h90 + 64'(i)); tick();
      end
      idle(); bus.issue_valid = 1'b1; bus.rs1_addr = 9; bus.rs1_used = 1'b1; #1;
      chk("sat_drained", 64'(bus.issue_stall), 64'd0);
      tick();

      idle(); issue(4); tick();
      issue(4); wb(4, 64'h44); #1;
      chk("inc_dec_issue", 64'(bus.issue_stall), 64'd0);
      tick();
      idle(); bus.issue_valid = 1'b1; bus.rs1_addr = 4; bus.rs1_used = 1'b1;
      bus.cancel_valid = 1'b1; bus.cancel_addr = 4; #1;
      chk("inc_dec_pend1", 64'(bus.issue_stall), 64'd1);
      tick();
      bus.cancel_valid = 1'b0; #1;
      chk("cancel_clear", 64'(bus.issue_stall), 64'd0);
      chk("cancel_nowrite", bus.rs1_data, 64'h44);
      tick();

      idle(); issue(2); tick(); tick();
      idle(); bus.issue_valid = 1'b1; bus.rs1_addr = 2; bus.rs1_used = 1'b1; #1;
      chk("mid_pend2", 64'(bus.issue_stall), 64'd1);
      rst = 1'b1; tick(); rst = 1'b0; #1;
      chk("mid_reset_clear", 64'(bus.issue_stall), 64'd0);
      idle(); wb(2, 64'h77); tick();
      idle(); bus.rs1_addr = 2; issue(2); #1;
      chk("mid_wb_data", bus.rs1_data, 64'h77);
      chk("mid_no_underflow", 64'(bus.issue_stall), 64'd0);
      tick();

      for (int c = 0; c < 3000; c++) begin
         rst                = ($urandom_range(0, 99) == 0);
         bus.wb_is_write_rf = $urandom_range(0, 1) == 1;
         bus.wb_addr        = 5'($urandom_range(0, 7));
         bus.wb_data        = {$urandom, $urandom};
         bus.cancel_valid   = $urandom_range(0, 9) == 0;
         bus.cancel_addr    = 5'($urandom_range(0, 7));
         bus.rs1_addr       = 5'($urandom_range(0, 7));
         bus.rs2_addr       = 5'($urandom_range(0, 7));
         bus.rs1_used       = $urandom_range(0, 9) < 7;
         bus.rs2_used       = $urandom_range(0, 9) < 7;
         bus.issue_valid    = $urandom_range(0, 9) < 6;
         bus.issue_wen      = $urandom_range(0, 9) < 7;
         bus.issue_rd       = 5'($urandom_range(0, 7));
         tick();
      end
      rst = 1'b0;
      idle();
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
